// File: rtl/clause_queue_if.sv
// clause_queue_if: handshake bundle between a clause arbiter (master) and one
// engine's clause queue (slave). The literal geometry comes from LIT_INDEX_MAX
// and CLA_LENGTH; sensible defaults are provided if the build does not set them.

`ifndef LIT_INDEX_MAX
`define LIT_INDEX_MAX 15
`endif
`ifndef CLA_LENGTH
`define CLA_LENGTH 3
`endif

interface clause_queue_if #(
  parameter int DEPTH = 4,
  parameter int CW    = `CLA_LENGTH * ($clog2(`LIT_INDEX_MAX) + 1)
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic            grant_in;
  logic [CW-1:0]   clause_in;
  logic            full_out;
  logic            pop_in;
  logic [CW-1:0]   clause_out;
  logic            valid_out;
  logic [CNTW-1:0] count_out;
  logic            overflow_err_out;

  // Arbiter side: grants clauses, engine side pops them.
  modport master (
    output grant_in, clause_in, pop_in,
    input  full_out, clause_out, valid_out, count_out, overflow_err_out
  );

  // Queue side.
  modport slave (
    input  grant_in, clause_in, pop_in,
    output full_out, clause_out, valid_out, count_out, overflow_err_out
  );
endinterface

// File: rtl/clause_queue.sv
// clause_queue: per-engine circular clause FIFO fed by the clause arbiter.
// full_out is derived only from registered occupancy so the arbiter's
// combinational grant loop never closes through this block.
// Optional feature: define CLAUSE_QUEUE_BYPASS_EN to let a clause granted into
// an empty queue appear on clause_out in the same cycle (and be consumed
// without being stored when pop_in is also high).

`ifndef LIT_INDEX_MAX
`define LIT_INDEX_MAX 15
`endif
`ifndef CLA_LENGTH
`define CLA_LENGTH 3
`endif

module clause_queue #(
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  clause_queue_if.slave bus
);
  localparam int EB   = $clog2(`LIT_INDEX_MAX) + 1;
  localparam int CW   = `CLA_LENGTH * EB;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  localparam logic [CNTW-1:0] C_FULL   = CNTW'(DEPTH);
  localparam logic [PW-1:0]   C_LASTIX = PW'(DEPTH - 1);

  // Storage is deliberately not reset; only control state is.
  logic [CW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_ovf;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_bypass;

  // Wrap explicitly at DEPTH-1 so non-power-of-two depths behave.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == C_LASTIX) ? '0 : ptr + PW'(1);
  endfunction

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

`ifdef CLAUSE_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & bus.grant_in;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed clause that is popped in the same cycle never enters storage.
  assign w_push = bus.grant_in & ~w_full & ~(w_bypass & bus.pop_in);
  assign w_pop  = bus.pop_in & ~w_empty;

  // Write pointer advances once per accepted push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= ptr_next(r_wr_ptr);
    end
  end

  // Read pointer advances once per pop of a non-empty queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= ptr_next(r_rd_ptr);
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: a grant seen while full_out is high is a lost clause.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (bus.grant_in && w_full) begin
      r_ovf <= 1'b1;
    end
  end

  // Clause storage write port.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.clause_in;
    end
  end

  // Head selection; the bypass path only exists when the macro is defined.
  always_comb begin
    bus.valid_out  = ~w_empty;
    bus.clause_out = r_mem[r_rd_ptr];
    if (w_bypass) begin
      bus.valid_out  = 1'b1;
      bus.clause_out = bus.clause_in;
    end
  end

  assign bus.full_out         = w_full;
  assign bus.count_out        = r_count;
  assign bus.overflow_err_out = r_ovf;

endmodule

// File: tb/tb_clause_queue.sv
// tb_clause_queue: drives a DEPTH=4 and a DEPTH=3 clause_queue with the same
// stimulus and compares both against a queue-based reference model.

`ifndef LIT_INDEX_MAX
`define LIT_INDEX_MAX 15
`endif
`ifndef CLA_LENGTH
`define CLA_LENGTH 3
`endif

module tb_clause_queue;
  localparam int CW = `CLA_LENGTH * ($clog2(`LIT_INDEX_MAX) + 1);

  logic clk;
  logic rst_n;

  clause_queue_if #(.DEPTH(4), .CW(CW)) b4 ();
  clause_queue_if #(.DEPTH(3), .CW(CW)) b3 ();

  clause_queue #(.DEPTH(4)) u_dut4 (.clock(clk), .reset(rst_n), .bus(b4));
  clause_queue #(.DEPTH(3)) u_dut3 (.clock(clk), .reset(rst_n), .bus(b3));

  logic          grant;
  logic [CW-1:0] clause;
  logic          pop;

  assign b4.grant_in  = grant;
  assign b4.clause_in = clause;
  assign b4.pop_in    = pop;
  assign b3.grant_in  = grant;
  assign b3.clause_in = clause;
  assign b3.pop_in    = pop;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CW-1:0] mq [2][$];
  bit            movf [2];
  int            mdep [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare both DUTs' outputs with what the model says they must show now.
  task automatic check_outputs(input logic g, input logic [CW-1:0] c);
    for (int d = 0; d < 2; d++) begin
      int            sz;
      logic          e_valid;
      logic [CW-1:0] e_clause;
      logic [4:0]    o_count;
      logic          o_full, o_valid, o_ovf;
      logic [CW-1:0] o_clause;
      string         nm;
      sz       = mq[d].size();
      e_valid  = (sz > 0);
      e_clause = (sz > 0) ? mq[d][0] : '0;
`ifdef CLAUSE_QUEUE_BYPASS_EN
      if (sz == 0 && g) begin
        e_valid  = 1'b1;
        e_clause = c;
      end
`endif
      if (d == 0) begin
        o_count = 5'(b4.count_out); o_full = b4.full_out; o_valid = b4.valid_out;
        o_ovf = b4.overflow_err_out; o_clause = b4.clause_out; nm = "d4";
      end else begin
        o_count = 5'(b3.count_out); o_full = b3.full_out; o_valid = b3.valid_out;
        o_ovf = b3.overflow_err_out; o_clause = b3.clause_out; nm = "d3";
      end
      chk({nm, ".count"}, 64'(o_count), 64'(sz));
      chk({nm, ".full"},  64'(o_full),  64'(sz == mdep[d]));
      chk({nm, ".valid"}, 64'(o_valid), 64'(e_valid));
      chk({nm, ".ovf"},   64'(o_ovf),   64'(movf[d]));
      if (e_valid) chk({nm, ".clause"}, 64'(o_clause), 64'(e_clause));
    end
  endtask

  // Apply the queue rules for one clock edge.
  task automatic model_update(input logic g, input logic [CW-1:0] c, input logic p);
    for (int d = 0; d < 2; d++) begin
      int sz;
      bit full, pop_ok, push_ok;
      sz      = mq[d].size();
      full    = (sz == mdep[d]);
      pop_ok  = p && sz > 0;
      push_ok = g && !full;
`ifdef CLAUSE_QUEUE_BYPASS_EN
      if (sz == 0 && g && p) push_ok = 0;
`endif
      if (g && full) movf[d] = 1;
      if (pop_ok) void'(mq[d].pop_front());
      if (push_ok) mq[d].push_back(c);
    end
  endtask

  // One cycle: drive at posedge+1, check, take the edge, advance the model.
  task automatic step(input logic g, input logic [CW-1:0] c, input logic p);
    grant = g; clause = c; pop = p;
    #1;
    check_outputs(g, c);
    @(posedge clk);
    model_update(g, c, p);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".d4.count"}, 64'(b4.count_out), 64'd0);
    chk({tag, ".d4.full"},  64'(b4.full_out),  64'd0);
    chk({tag, ".d4.valid"}, 64'(b4.valid_out), 64'd0);
    chk({tag, ".d4.ovf"},   64'(b4.overflow_err_out), 64'd0);
    chk({tag, ".d3.count"}, 64'(b3.count_out), 64'd0);
    chk({tag, ".d3.full"},  64'(b3.full_out),  64'd0);
    chk({tag, ".d3.valid"}, 64'(b3.valid_out), 64'd0);
    chk({tag, ".d3.ovf"},   64'(b3.overflow_err_out), 64'd0);
  endtask

  function automatic logic [CW-1:0] rnd_clause();
    return CW'($urandom);
  endfunction

  initial begin
    mdep[0] = 4; mdep[1] = 3;
    movf[0] = 0; movf[1] = 0;
    grant = 0; clause = '0; pop = 0;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("rst");
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill with A..D, then overflow with E, then drain.
    step(1, CW'(15'h0A1), 0);
    step(1, CW'(15'h0B2), 0);
    step(1, CW'(15'h0C3), 0);
    step(1, CW'(15'h0D4), 0);
    step(1, CW'(15'h0E5), 0);
    step(0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1);
    step(0, '0, 0);

    // Pop together with a full-queue grant: pop wins, grant still overflows.
    for (int i = 0; i < 4; i++) step(1, rnd_clause(), 0);
    step(1, rnd_clause(), 1);
    for (int i = 0; i < 5; i++) step(0, '0, 1);

    // Streaming through pointer wrap: pop every cycle from the second push.
    step(1, rnd_clause(), 0);
    for (int i = 0; i < 4; i++) step(1, rnd_clause(), 1);
    step(0, '0, 1);
    step(0, '0, 0);

    // Pops on an empty queue are ignored.
    for (int i = 0; i < 3; i++) step(0, '0, 1);
    step(1, CW'(15'h1234), 0);
    step(0, '0, 1);
    step(0, '0, 0);

    // Asynchronous reset between edges with two clauses queued.
    step(1, rnd_clause(), 0);
    step(1, rnd_clause(), 0);
    grant = 0; pop = 0;
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    mq[0].delete(); mq[1].delete();
    movf[0] = 0; movf[1] = 0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, CW'(15'h5A5A), 0);
    step(0, '0, 0);
    step(0, '0, 1);

    // Grant plus pop on an empty queue.
    step(1, CW'(15'h3C3C), 1);
    step(0, '0, 0);
    step(0, '0, 1);
    step(0, '0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), rnd_clause(), ($urandom_range(0, 9) < 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound on the run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
